// File: rtl/cordic_axil_sequencer_if.sv
// AXI4-Lite bus bundle used by the CORDIC job sequencer.
// master: sequencer side (drives AW/W/AR, B/R ready); slave: register block side.
interface cordic_axil_sequencer_if;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  modport master (
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input  m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input  m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input  m_awaddr, m_awvalid, output m_awready,
    input  m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input  m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/cordic_axil_sequencer.sv
// CORDIC job sequencer: one angle/mode job in, one result word out,
// driving the cordic_system register block over AXI4-Lite.
// Ports: aclk/aresetn; req_* job request; rsp_* result; busy; m AXI master.
module cordic_axil_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_angle,
  input  logic        req_mode,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy,
  cordic_axil_sequencer_if.master m
);

  localparam int CW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE, W_ANGLE, W_MODE, W_START,
    W_CLR, POLL, R_RES, RESP
  } state_t;

  state_t         state, state_n;
  logic           mode_q;
  logic [CW-1:0]  poll_cnt;
  logic           aw_hs, w_hs, b_hs;
  logic           ar_hs, r_hs;
  logic           issue_w, issue_r;
  logic [31:0]    addr_n, data_n, ctrl;
  logic [3:0]     strb_n;
  logic [31:0]    rsp_data_n;
  logic [1:0]     rsp_status_n;

  assign aw_hs = m.m_awvalid & m.m_awready;
  assign w_hs  = m.m_wvalid & m.m_wready;
  assign b_hs  = m.m_bvalid & m.m_bready;
  assign ar_hs = m.m_arvalid & m.m_arready;
  assign r_hs  = m.m_rvalid & m.m_rready;

  assign ctrl      = {29'd0, mode_q, 2'b00};
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n      = state;
    rsp_data_n   = '0;
    rsp_status_n = 2'b00;
    unique case (state)
      IDLE:    if (req_valid) state_n = W_ANGLE;
      W_ANGLE: if (b_hs) state_n = W_MODE;
      W_MODE:  if (b_hs) state_n = W_START;
      W_START: if (b_hs) state_n = W_CLR;
      W_CLR:   if (b_hs) state_n = POLL;
      POLL: begin
        if (r_hs) begin
          if (m.m_rdata[0]) begin
            state_n = R_RES;
          end else if (poll_cnt == CW'(POLL_LIMIT - 1)) begin
            state_n      = RESP;
            rsp_status_n = 2'b10;
          end
        end
      end
      R_RES: begin
        if (r_hs) begin
          state_n    = RESP;
          rsp_data_n = m.m_rdata;
        end
      end
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A failed response ends the job at once; nothing else goes out.
    if ((b_hs && m.m_bresp != 2'b00) ||
        (r_hs && m.m_rresp != 2'b00)) begin
      state_n      = RESP;
      rsp_data_n   = '0;
      rsp_status_n = 2'b01;
    end
  end

  always_comb begin
    addr_n = BASE_ADDR + 32'h8;
    data_n = ctrl;
    strb_n = 4'h1;
    unique case (state_n)
      W_ANGLE: begin
        addr_n = BASE_ADDR;
        data_n = req_angle;
        strb_n = 4'hF;
      end
      W_START: data_n = ctrl | 32'h2;
      POLL:    addr_n = BASE_ADDR + 32'hC;
      R_RES:   addr_n = BASE_ADDR + 32'h4;
      default: ;
    endcase
  end

  // A repeated poll is a new transaction even though the state is unchanged.
  assign issue_w = (state_n != state) &&
    (state_n inside {W_ANGLE, W_MODE, W_START, W_CLR});
  assign issue_r = (state_n inside {POLL, R_RES}) &&
    ((state_n != state) || r_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q      <= 1'b0;
      poll_cnt    <= '0;
      m.m_awaddr  <= '0;
      m.m_awvalid <= 1'b0;
      m.m_wdata   <= '0;
      m.m_wstrb   <= '0;
      m.m_wvalid  <= 1'b0;
      m.m_bready  <= 1'b0;
      m.m_araddr  <= '0;
      m.m_arvalid <= 1'b0;
      m.m_rready  <= 1'b0;
      rsp_data    <= '0;
      rsp_status  <= 2'b00;
    end else begin
      if (state == IDLE && req_valid) mode_q <= req_mode;

      if (issue_w) begin
        m.m_awaddr  <= addr_n;
        m.m_wdata   <= data_n;
        m.m_wstrb   <= strb_n;
        m.m_awvalid <= 1'b1;
        m.m_wvalid  <= 1'b1;
        m.m_bready  <= 1'b1;
      end else begin
        if (aw_hs) m.m_awvalid <= 1'b0;
        if (w_hs)  m.m_wvalid  <= 1'b0;
        if (b_hs)  m.m_bready  <= 1'b0;
      end

      if (issue_r) begin
        m.m_araddr  <= addr_n;
        m.m_arvalid <= 1'b1;
        m.m_rready  <= 1'b1;
      end else begin
        if (ar_hs) m.m_arvalid <= 1'b0;
        if (r_hs)  m.m_rready  <= 1'b0;
      end

      if (state_n == RESP && state != RESP) begin
        rsp_data   <= rsp_data_n;
        rsp_status <= rsp_status_n;
      end

      if (state == RESP && rsp_ready)
        poll_cnt <= '0;
      else if (state == POLL && r_hs)
        poll_cnt <= poll_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_axil_sequencer.sv
// Randomised scoreboard bench for the CORDIC job sequencer.
// A behavioural AXI slave logs every transaction; a monitor checks responses.
module tb_cordic_axil_sequencer;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int PL = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_angle = '0;
  logic        req_mode = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;

  cordic_axil_sequencer_if axi ();

  cordic_axil_sequencer #(
    .BASE_ADDR (BASE),
    .POLL_LIMIT(PL)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_angle (req_angle),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_status(rsp_status),
    .busy      (busy),
    .m         (axi.master)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    int          lat;
  } rsp_t;

  txn_t exp_txn[$];
  rsp_t exp_rsp[$];

  int compared = 0;
  int mismatched = 0;

  int cfg_awd = 0, cfg_wd = 0, cfg_done = 1;
  int cfg_err = -1, cfg_rspd = 0;
  logic [31:0] cfg_res = '0;
  int acc_cyc = 0;
  int wr_idx = 0, polls = 0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Expected bus traffic and result of one job, from the register-map rules.
  task automatic model(input logic [31:0] ang, input bit mode,
                       input bit want_rsp);
    logic [31:0] mv;
    txn_t t;
    rsp_t r;
    int lat, npoll, wait_w;
    bit err, done;
    mv = 32'(mode) << 2;
    lat = 0;
    err = 0;
    wait_w = (cfg_awd > cfg_wd) ? cfg_awd : cfg_wd;
    for (int i = 0; i < 4 && !err; i++) begin
      t.wr = 1;
      t.addr = (i == 0) ? BASE : BASE + 8;
      t.data = (i == 0) ? ang : ((i == 2) ? (mv | 2) : mv);
      t.strb = (i == 0) ? 4'hF : 4'h1;
      exp_txn.push_back(t);
      lat += 2 + wait_w;
      if (cfg_err == i) err = 1;
    end
    done = (cfg_done >= 1 && cfg_done <= PL);
    npoll = done ? cfg_done : PL;
    for (int p = 1; p <= npoll && !err; p++) begin
      t = '{wr: 0, addr: BASE + 12, data: 0, strb: 0};
      exp_txn.push_back(t);
      lat += 2;
      if (cfg_err == 5 && p == 1) err = 1;
    end
    if (!err && done) begin
      t = '{wr: 0, addr: BASE + 4, data: 0, strb: 0};
      exp_txn.push_back(t);
      lat += 2;
      if (cfg_err == 6) err = 1;
    end
    if (err)       r = '{data: 0, status: 2'b01, lat: lat};
    else if (done) r = '{data: cfg_res, status: 2'b00, lat: lat};
    else           r = '{data: 0, status: 2'b10, lat: lat};
    if (want_rsp) exp_rsp.push_back(r);
  endtask

  task automatic log_txn(input txn_t t);
    txn_t e;
    if (exp_txn.size() == 0) begin
      chk("txn_unexpected", {3'b0, t.wr, t.addr, t.data, t.strb}, 72'h0);
    end else begin
      e = exp_txn.pop_front();
      chk("txn", {3'b0, t.wr, t.addr, t.data, t.strb},
                 {3'b0, e.wr, e.addr, e.data, e.strb});
    end
  endtask

  // Behavioural register-block slave, driven on the falling edge.
  initial begin : slave
    bit aw_done, w_done, ar_done;
    int aw_cnt, w_cnt;
    logic [31:0] aw_hold, wd_hold, ar_hold, rd;
    logic [3:0] ws_hold;
    txn_t t;
    aw_done = 0; w_done = 0; ar_done = 0;
    aw_cnt = 0; w_cnt = 0;
    aw_hold = 0; wd_hold = 0; ws_hold = 0; ar_hold = 0;
    axi.m_awready = 0; axi.m_wready = 0;
    axi.m_bvalid = 0; axi.m_bresp = 0;
    axi.m_arready = 0; axi.m_rvalid = 0;
    axi.m_rdata = 0; axi.m_rresp = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0;
        axi.m_awready = 0; axi.m_wready = 0;
        axi.m_bvalid = 0; axi.m_arready = 0;
        axi.m_rvalid = 0;
        continue;
      end
      if (axi.m_awvalid || axi.m_wvalid || axi.m_arvalid)
        chk("aw_ar_overlap",
            72'((axi.m_awvalid | axi.m_wvalid) & axi.m_arvalid), 72'h0);
      if (axi.m_awready) begin
        axi.m_awready = 0;
        aw_done = 1;
      end else if (axi.m_awvalid && !aw_done) begin
        if (aw_cnt == 0) aw_hold = axi.m_awaddr;
        else chk("aw_stable", 72'(axi.m_awaddr), 72'(aw_hold));
        if (aw_cnt >= cfg_awd) axi.m_awready = 1;
        aw_cnt++;
      end
      if (axi.m_wready) begin
        axi.m_wready = 0;
        w_done = 1;
      end else if (axi.m_wvalid && !w_done) begin
        if (w_cnt == 0) begin
          wd_hold = axi.m_wdata;
          ws_hold = axi.m_wstrb;
        end else begin
          chk("w_stable", {36'h0, axi.m_wstrb, axi.m_wdata},
                          {36'h0, ws_hold, wd_hold});
        end
        if (w_cnt >= cfg_wd) axi.m_wready = 1;
        w_cnt++;
      end
      if (axi.m_bvalid) begin
        axi.m_bvalid = 0;
      end else if (aw_done && w_done) begin
        t = '{wr: 1, addr: aw_hold, data: wd_hold, strb: ws_hold};
        log_txn(t);
        chk("bready", 72'(axi.m_bready), 72'h1);
        axi.m_bresp = (wr_idx == cfg_err) ? 2'b10 : 2'b00;
        if (aw_hold == BASE + 8 && wd_hold[1]) polls = 0;
        wr_idx++;
        axi.m_bvalid = 1;
        aw_done = 0; w_done = 0;
        aw_cnt = 0; w_cnt = 0;
      end
      if (axi.m_arready) begin
        axi.m_arready = 0;
        ar_done = 1;
      end else if (axi.m_arvalid && !ar_done) begin
        ar_hold = axi.m_araddr;
        axi.m_arready = 1;
      end
      if (axi.m_rvalid) begin
        axi.m_rvalid = 0;
      end else if (ar_done) begin
        ar_done = 0;
        t = '{wr: 0, addr: ar_hold, data: 0, strb: 0};
        log_txn(t);
        chk("rready", 72'(axi.m_rready), 72'h1);
        axi.m_rresp = 2'b00;
        rd = $urandom;
        if (ar_hold == BASE + 12) begin
          polls++;
          rd[0] = (cfg_done != 0 && polls >= cfg_done);
          if (cfg_err == 5 && polls == 1) axi.m_rresp = 2'b10;
        end else begin
          rd = cfg_res;
          if (cfg_err == 6) axi.m_rresp = 2'b11;
        end
        axi.m_rdata = rd;
        axi.m_rvalid = 1;
      end
    end
  end

  // Response monitor: pops the scoreboard when a result appears.
  initial begin : monitor
    bit seen;
    int hold;
    logic [31:0] h_data;
    logic [1:0] h_st;
    rsp_t e;
    seen = 0; hold = 0; h_data = 0; h_st = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        rsp_ready = 0;
        seen = 0;
        continue;
      end
      if (rsp_ready) begin
        rsp_ready = 0;
        seen = 0;
      end else if (rsp_valid) begin
        if (!seen) begin
          seen = 1;
          hold = cfg_rspd;
          h_data = rsp_data;
          h_st = rsp_status;
          if (exp_rsp.size() == 0) begin
            chk("rsp_unexpected", {38'h0, rsp_status, rsp_data}, 72'h0);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_data", 72'(rsp_data), 72'(e.data));
            chk("rsp_status", 72'(rsp_status), 72'(e.status));
            chk("latency", 72'(cyc - acc_cyc), 72'(e.lat));
          end
        end else begin
          chk("rsp_stable", {38'h0, rsp_status, rsp_data},
                            {38'h0, h_st, h_data});
          chk("hold_flags", {70'h0, req_ready, busy}, 72'h1);
        end
        if (hold == 0) rsp_ready = 1;
        else hold--;
      end
    end
  end

  task automatic issue(input logic [31:0] ang, input bit mode,
                       input bit want_rsp);
    int n;
    wr_idx = 0;
    polls = 0;
    model(ang, mode, want_rsp);
    @(negedge aclk);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("req_ready_wait", 72'(req_ready), 72'h1);
    req_angle = ang;
    req_mode = mode;
    req_valid = 1;
    @(posedge aclk);
    @(negedge aclk);
    acc_cyc = cyc;
    req_valid = 0;
    req_angle = $urandom;
    req_mode = $urandom_range(0, 1);
  endtask

  task automatic run_job(input logic [31:0] ang, input bit mode);
    int n;
    issue(ang, mode, 1);
    n = 0;
    while (busy && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    chk("job_done", 72'(busy), 72'h0);
  endtask

  task automatic set_cfg(input int awd, input int wd, input int done,
                         input int err, input int rspd,
                         input logic [31:0] res);
    cfg_awd = awd;
    cfg_wd = wd;
    cfg_done = done;
    cfg_err = err;
    cfg_rspd = rspd;
    cfg_res = res;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, r;
    #12;
    chk("reset_flags",
        {64'h0, axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid,
         axi.m_rready, rsp_valid, req_ready, busy}, 72'h2);
    chk("reset_bus", {axi.m_wstrb, axi.m_awaddr, axi.m_wdata},
                     {4'h0, 32'h0, 32'h0});
    chk("reset_rsp", {38'h0, rsp_status, rsp_data, axi.m_araddr[1:0]},
                     72'h0);
    @(negedge aclk);
    aresetn = 1;

    set_cfg(0, 0, 3, -1, 0, 32'h0001_0000);
    run_job(32'h0000_0000, 0);

    set_cfg(0, 0, 1, -1, 0, $urandom);
    run_job(32'h005A_0000, 1);

    set_cfg(3, 0, 2, -1, 5, $urandom);
    run_job($urandom, $urandom_range(0, 1));

    set_cfg(0, 0, 1, 2, 0, $urandom);
    run_job(32'h0012_3456, 1);
    set_cfg(0, 0, 1, -1, 0, $urandom);
    run_job(32'h001E_0000, 0);

    set_cfg(0, 0, 0, -1, 0, $urandom);
    run_job(32'h002D_0000, 1);

    set_cfg(0, 0, 0, -1, 0, $urandom);
    issue(32'h0000_0000, 0, 0);
    n = 0;
    while (polls < 1 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("reached_poll", 72'(polls >= 1), 72'h1);
    @(posedge aclk);
    #2 aresetn = 0;
    #1;
    chk("midjob_reset",
        {64'h0, axi.m_awvalid, axi.m_wvalid, axi.m_bready, axi.m_arvalid,
         axi.m_rready, rsp_valid, req_ready, busy}, 72'h2);
    exp_txn.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1;
    set_cfg(0, 0, 3, -1, 0, 32'h0001_0000);
    run_job(32'h0000_0000, 0);

    for (int j = 0; j < 40; j++) begin
      r = $urandom_range(0, 10);
      set_cfg(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 5),
              (r < 5) ? -1 : (r < 9) ? r - 5 : (r == 9) ? 5 : 6,
              $urandom_range(0, 5), $urandom);
      run_job($urandom, $urandom_range(0, 1));
    end

    repeat (3) @(negedge aclk);
    chk("txn_queue_empty", 72'(exp_txn.size()), 72'h0);
    chk("rsp_queue_empty", 72'(exp_rsp.size()), 72'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cordic_axil_sequencer.md
Name: cordic_axil_sequencer

Overview:
- AXI4-Lite master that runs one CORDIC job per accepted request against the cordic_system register map: angle 0x0, result 0x4, control 0x8 (bit1 start, bit2 mode), flags 0xC (bit0 done).
- Takes angle/mode jobs on a valid/ready request port and returns the result word on a valid/ready response port.
- Replaces software register sequencing; sits between a job source (DMA or stream) and the cordic_system slave port.

Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the cordic_system register block.
- POLL_LIMIT, 1024, maximum reads of the flags register per job before timeout (>=1).

Ports:
- aclk  in  1  system clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  job request valid
- req_ready  out  1  sequencer idle, can accept a job
- req_angle  in  32  Q16.16 angle in degrees, passed unchanged
- req_mode  in  1  0 = cosine, 1 = sine
- rsp_valid  out  1  job result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result register value, or 0 on error
- rsp_status  out  2  00 ok, 01 bus error, 10 poll timeout
- busy  out  1  high from job accept until response handshake
- m_awaddr out 32, m_awvalid out 1, m_awready in 1: AXI write address channel
- m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1: AXI write data channel
- m_bresp in 2, m_bvalid in 1, m_bready out 1: AXI write response channel
- m_araddr out 32, m_arvalid out 1, m_arready in 1: AXI read address channel
- m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1: AXI read data channel

Behaviour:
- Reset (async, immediate):
  - all valid/ready outputs 0 except req_ready = 1.
  - addr/data outputs 0; m_wstrb 0; rsp_status 00; busy 0; poll counter 0; state IDLE.
- States: IDLE, W_ANGLE, W_MODE, W_START, W_CLR, POLL, R_RES, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, latch angle/mode, go to W_ANGLE. req_ready = 0 in every other state; there is no queueing.
- Writes, with M = mode << 2:
  - W_ANGLE: addr BASE+0x0, data angle, strb 1111.
  - W_MODE: addr BASE+0x8, data M, strb 0001.
  - W_START: addr BASE+0x8, data M | 0x2, strb 0001.
  - W_CLR: addr BASE+0x8, data M, strb 0001.
- Write protocol:
  - m_awvalid and m_wvalid are registered and both asserted the cycle after entering the state.
  - Each is held, with stable addr/data/strb, until its own ready is sampled high; AW and W complete independently, in either order or together.
  - m_bready is high from entry until the B handshake.
  - The next state is entered the cycle after the B handshake.
- Read protocol:
  - m_arvalid is held until m_arready; m_rready is high from entry until the R handshake.
  - m_rdata and m_rresp are captured on the R handshake.
- POLL:
  - reads BASE+0xC and increments the poll counter per completed read.
  - rdata bit0 = 1 → R_RES.
  - bit0 = 0 and counter < POLL_LIMIT → issue another read.
  - bit0 = 0 and counter == POLL_LIMIT → RESP with status 10.
- R_RES: reads BASE+0x4; rsp_data = rdata; goes to RESP with status 00.
- Errors:
  - any bresp or rresp != 00 → RESP immediately, status 01, rsp_data 0.
  - no further AXI transactions are issued for that job; a stale start bit is cleared by the next job's W_MODE.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_status stay stable until rsp_ready.
  - after the handshake, the next cycle enters IDLE with req_ready = 1; the poll counter clears.
- Never more than one outstanding AXI transaction; AW/W and AR are never active in the same cycle.
- Minimum latency with zero-wait slave and done on first poll: 4 writes × 2 cycles + 2 reads × 2 cycles = 12 cycles from accept to rsp_valid.
- Reset mid-transaction: the in-flight handshake is abandoned; the slave must share the same reset.

Test Plan:
- cos(0): angle 0x00000000, mode 0, slave done on 3rd poll, result 0x00010000 → writes (0x0,0,F), (0x8,0,1), (0x8,2,1), (0x8,0,1); exactly 3 reads of 0xC then 1 read of 0x4; rsp_data 0x00010000, status 00.
- sin(90): angle 0x005A0000, mode 1 → control write data 4, 6, 4 in order; rsp_data equals the slave result; zero-wait slave gives rsp_valid 12 cycles after accept.
- Backpressure: awready delayed 3 cycles while wready is immediate, rsp_ready low for 5 cycles → AW signals stable while waiting; rsp_data/status stable; req_ready low until the response handshake.
- Bus error: bresp 2'b10 on the W_START write → no W_CLR or reads issued; rsp_status 01, rsp_data 0; next job runs normally.
- Timeout: POLL_LIMIT 4, done never set → exactly 4 reads of 0xC, no read of 0x4, rsp_status 10.
- Reset during POLL: aresetn low → all m_*valid, m_bready, m_rready and rsp_valid go to 0 without a clock edge; after release, req_ready = 1 and a fresh cos(0) job completes.
